// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
//
// Parallel-to-serial front end that feeds the serial sequence detector.
// Words arrive over a valid/ready handshake and leave one bit per clock on
// ser_out. A single holding register lets a second word wait while the
// current one is shifting. This keeps back-to-back words flowing with no idle
// cycle between them. When no word is being shifted the line sits at
// IDLE_BIT, because the detector samples its input on every cycle.
//
// Parameters:
//   DATA_W     word width in bits (2 or more)
//   MSB_FIRST  1: din[DATA_W-1] goes out first, 0: din[0] goes out first
//   IDLE_BIT   level driven on ser_out while no word is being shifted
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   reset       asynchronous, active-low reset
//   din         parallel word to serialize
//   din_valid   din holds a valid word
//   din_ready   block can accept a word this cycle
//   ser_out     serial bit stream to the detector
//   ser_active  ser_out carries a data bit this cycle
//   frame_done  ser_out carries the last bit of a word this cycle
// -----------------------------------------------------------------------------
module serial_bit_feeder #(
  parameter int   DATA_W    = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ser_out,
  output logic              ser_active,
  output logic              frame_done
);

  localparam int                 CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(DATA_W - 1);
  localparam int unsigned        LAST_IDX = DATA_W - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] hold_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              hold_full;
  logic              hold_full_next;
  logic              accept;
  logic              last_bit;
  logic              cnt_bad;

  // The reset term keeps din_ready low for as long as reset is held, so no
  // word can be accepted while the block is being cleared.
  assign din_ready = reset & ~hold_full;
  assign accept    = din_valid & din_ready;

  assign last_bit  = (bit_cnt == LAST_CNT);

  // The counter can only leave the legal range when DATA_W is not a power of
  // two, for example after an upset. That case drops the block back to IDLE.
  assign cnt_bad   = (32'(bit_cnt) > LAST_IDX);

  // The shifter moves toward the output end, so the bit on ser_out is always
  // the same end bit of shift_reg.
  always_comb begin
    shifted = shift_reg;
    if (MSB_FIRST != 0) begin
      shifted = {shift_reg[DATA_W-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shift_reg[DATA_W-1:1]};
    end
  end

  // Next-state logic.
  // On the last-bit edge, a held word takes priority. If no word is held,
  // a word accepted on that same edge bypasses the hold register and goes
  // straight into the shifter, so no idle cycle appears between words.
  always_comb begin
    state_next     = state;
    shift_next     = shift_reg;
    cnt_next       = bit_cnt;
    hold_next      = hold_reg;
    hold_full_next = hold_full;

    case (state)
      IDLE: begin
        if (accept) begin
          shift_next = din;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_bad) begin
          state_next     = IDLE;
          cnt_next       = '0;
          hold_full_next = 1'b0;
        end else if (!last_bit) begin
          shift_next = shifted;
          cnt_next   = bit_cnt + CNT_W'(1);
          if (accept) begin
            hold_next      = din;
            hold_full_next = 1'b1;
          end
        end else if (hold_full) begin
          shift_next     = hold_reg;
          hold_full_next = 1'b0;
          cnt_next       = '0;
        end else if (accept) begin
          shift_next = din;
          cnt_next   = '0;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end

      default: begin
        state_next     = IDLE;
        cnt_next       = '0;
        hold_full_next = 1'b0;
      end
    endcase
  end

  // State register. Reset discards the word being shifted and any held word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= cnt_next;
      hold_reg  <= hold_next;
      hold_full <= hold_full_next;
    end
  end

  // All outputs decode only registered state. They therefore change only
  // after a rising edge (or an asynchronous reset) and are stable across the
  // falling edge where the detector samples them.
  assign ser_active = (state == SHIFT);
  assign frame_done = ser_active & last_bit;

  always_comb begin
    ser_out = IDLE_BIT;
    if (ser_active) begin
      ser_out = (MSB_FIRST != 0) ? shift_reg[DATA_W-1] : shift_reg[0];
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_feeder
//
// Self-checking bench for serial_bit_feeder. It uses two instances:
//   dut      DATA_W=8, MSB first, idle level 0
//   dut_lsb  DATA_W=8, LSB first, idle level 1
//
// Each accepted word pushes its expected bits onto a scoreboard queue. On
// every falling edge, one entry is popped and compared against ser_out,
// ser_active and frame_done. An empty queue means the line must be idle.
// -----------------------------------------------------------------------------
module tb_serial_bit_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         ser_out;
  logic         ser_active;
  logic         frame_done;
  logic [W-1:0] din2;
  logic         din_valid2;
  logic         din_ready2;
  logic         ser_out2;
  logic         ser_active2;
  logic         frame_done2;

  serial_bit_feeder #(.DATA_W(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .ser_out    (ser_out),
    .ser_active (ser_active),
    .frame_done (frame_done)
  );

  serial_bit_feeder #(.DATA_W(W), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .din        (din2),
    .din_valid  (din_valid2),
    .din_ready  (din_ready2),
    .ser_out    (ser_out2),
    .ser_active (ser_active2),
    .frame_done (frame_done2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_q2[$];

  int           n_vec      = 0;
  int           n_err      = 0;
  int           n_viol     = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_din   = '0;
  logic         last_rdy;
  logic         last_acc;

  // Drives one clock worth of inputs. It records whether the word was taken,
  // pushes the expected bits of every accepted word, and then advances to the
  // next falling edge, where the caller samples the outputs.
  task automatic drive(input logic v, input logic [W-1:0] d,
                       input logic v2, input logic [W-1:0] d2);
    din_valid  = v;
    din        = d;
    din_valid2 = v2;
    din2       = d2;
    #1;
    last_rdy = din_ready;
    last_acc = v && din_ready;
    if (v && prev_stall && (d !== prev_din)) begin
      n_viol++;
      $display("[TB] protocol violation: din changed while stalled (%h -> %h)", prev_din, d);
    end
    prev_stall = v && !din_ready;
    prev_din   = d;
    if (last_acc) begin
      for (int i = W - 1; i >= 0; i--) sb_q.push_back(exp_t'{b: d[i], last: (i == 0)});
    end
    if (v2 && din_ready2) begin
      for (int i = 0; i < W; i++) sb_q2.push_back(exp_t'{b: d2[i], last: (i == W - 1)});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    din_valid = 1'b1;
    din       = 8'hFF;
    @(negedge clk);
    n_vec++;
    if ({din_ready, ser_out, ser_active, frame_done} !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL reset_main: ready/out/act/done=%b%b%b%b expected 0000",
               din_ready, ser_out, ser_active, frame_done);
    end
    n_vec++;
    if ({din_ready2, ser_out2, ser_active2, frame_done2} !== 4'b0100) begin
      n_err++;
      $display("[TB] FAIL reset_lsb: ready/out/act/done=%b%b%b%b expected 0100",
               din_ready2, ser_out2, ser_active2, frame_done2);
    end
    din_valid = 1'b0;
    din       = '0;
    reset     = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({din_ready, ser_active, ser_out} !== 3'b100) begin
      n_err++;
      $display("[TB] FAIL reset_release: ready/act/out=%b%b%b expected 100",
               din_ready, ser_active, ser_out);
    end
  endtask

  task automatic test_single_word();
    logic xa, xb, xf;
    exp_t e;
    for (int c = 0; c < 11; c++) begin
      drive(c == 0, 8'b1011_0110, 1'b0, '0);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front(); xa = 1'b1; xb = e.b; xf = e.last;
      end else begin
        xa = 1'b0; xb = 1'b0; xf = 1'b0;
      end
      n_vec++;
      if ({ser_active, ser_out, frame_done} !== {xa, xb, xf}) begin
        n_err++;
        $display("[TB] FAIL single cyc%0d: act/out/done=%b%b%b expected %b%b%b",
                 c, ser_active, ser_out, frame_done, xa, xb, xf);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [2];
    int           idx;
    logic         v, xa, xb, xf, xr;
    exp_t         e;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    idx = 0;
    for (int k = 0; k < 20; k++) begin
      v = (idx < 2);
      drive(v, v ? words[idx] : '0, 1'b0, '0);
      xr = !(k >= 2 && k <= 8);
      n_vec++;
      if (last_rdy !== xr) begin
        n_err++;
        $display("[TB] FAIL b2b_ready cyc%0d: din_ready=%b expected %b", k, last_rdy, xr);
      end
      if (last_acc) idx++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front(); xa = 1'b1; xb = e.b; xf = e.last;
      end else begin
        xa = 1'b0; xb = 1'b0; xf = 1'b0;
      end
      n_vec++;
      if ({ser_active, ser_out, frame_done} !== {xa, xb, xf}) begin
        n_err++;
        $display("[TB] FAIL b2b cyc%0d: act/out/done=%b%b%b expected %b%b%b",
                 k, ser_active, ser_out, frame_done, xa, xb, xf);
      end
    end
  endtask

  task automatic test_bypass();
    logic v, xa, xb, xf;
    exp_t e;
    for (int k = 0; k < 20; k++) begin
      v = (k == 0) || (k == 8);
      drive(v, (k == 0) ? 8'hC3 : 8'h5A, 1'b0, '0);
      if (k == 8 || k == 9) begin
        n_vec++;
        if (last_rdy !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL bypass_ready cyc%0d: din_ready=%b expected 1", k, last_rdy);
        end
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front(); xa = 1'b1; xb = e.b; xf = e.last;
      end else begin
        xa = 1'b0; xb = 1'b0; xf = 1'b0;
      end
      n_vec++;
      if ({ser_active, ser_out, frame_done} !== {xa, xb, xf}) begin
        n_err++;
        $display("[TB] FAIL bypass cyc%0d: act/out/done=%b%b%b expected %b%b%b",
                 k, ser_active, ser_out, frame_done, xa, xb, xf);
      end
    end
  endtask

  task automatic test_lsb_first();
    logic xa, xb, xf;
    exp_t e;
    n_vec++;
    if ({ser_active2, ser_out2} !== 2'b01) begin
      n_err++;
      $display("[TB] FAIL lsb_idle: act/out=%b%b expected 01", ser_active2, ser_out2);
    end
    for (int k = 0; k < 11; k++) begin
      drive(1'b0, '0, k == 0, 8'h01);
      if (sb_q2.size() > 0) begin
        e = sb_q2.pop_front(); xa = 1'b1; xb = e.b; xf = e.last;
      end else begin
        xa = 1'b0; xb = 1'b1; xf = 1'b0;
      end
      n_vec++;
      if ({ser_active2, ser_out2, frame_done2} !== {xa, xb, xf}) begin
        n_err++;
        $display("[TB] FAIL lsb cyc%0d: act/out/done=%b%b%b expected %b%b%b",
                 k, ser_active2, ser_out2, frame_done2, xa, xb, xf);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic xa, xb, xf;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      drive(k < 2, (k == 0) ? 8'hFF : 8'h81, 1'b0, '0);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front(); xa = 1'b1; xb = e.b; xf = e.last;
      end else begin
        xa = 1'b0; xb = 1'b0; xf = 1'b0;
      end
      n_vec++;
      if ({ser_active, ser_out, frame_done} !== {xa, xb, xf}) begin
        n_err++;
        $display("[TB] FAIL rstmid_pre cyc%0d: act/out/done=%b%b%b expected %b%b%b",
                 k, ser_active, ser_out, frame_done, xa, xb, xf);
      end
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({din_ready, ser_active, ser_out, frame_done} !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL rstmid_async: ready/act/out/done=%b%b%b%b expected 0000",
               din_ready, ser_active, ser_out, frame_done);
    end
    sb_q.delete();
    sb_q2.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, '0, 1'b0, '0);
      if (k == 0) begin
        n_vec++;
        if (last_rdy !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL rstmid_ready: din_ready=%b expected 1", last_rdy);
        end
      end
      n_vec++;
      if ({ser_active, ser_out, frame_done} !== 3'b000) begin
        n_err++;
        $display("[TB] FAIL rstmid_post cyc%0d: act/out/done=%b%b%b expected 000",
                 k, ser_active, ser_out, frame_done);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d;
    int           idx;
    int           viol0;
    logic         v, xa, xb, xf;
    exp_t         e;
    idx   = 0;
    viol0 = n_viol;
    for (int k = 0; k < 28; k++) begin
      v = (idx < 3);
      if (idx == 0)      d = 8'hF0;
      else if (idx == 1) d = 8'h96;
      else               d = (k <= 2) ? 8'h11 : 8'h22;
      drive(v, v ? d : '0, 1'b0, '0);
      if (last_acc) idx++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front(); xa = 1'b1; xb = e.b; xf = e.last;
      end else begin
        xa = 1'b0; xb = 1'b0; xf = 1'b0;
      end
      n_vec++;
      if ({ser_active, ser_out, frame_done} !== {xa, xb, xf}) begin
        n_err++;
        $display("[TB] FAIL bp cyc%0d: act/out/done=%b%b%b expected %b%b%b",
                 k, ser_active, ser_out, frame_done, xa, xb, xf);
      end
    end
    n_vec++;
    if (idx != 3) begin
      n_err++;
      $display("[TB] FAIL bp_accept: words accepted=%0d expected 3 (timeout)", idx);
    end
    n_vec++;
    if (n_viol - viol0 != 1) begin
      n_err++;
      $display("[TB] FAIL bp_protocol: violations flagged=%0d expected 1", n_viol - viol0);
    end
  endtask

  initial begin
    reset      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    din2       = '0;
    din_valid2 = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bypass();
    test_lsb_first();
    test_reset_mid_word();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests incomplete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
